ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: SPARC-style execute stage with registered EX/MEM payload, branch resolution, icc and Y.
// Optional EX_MUL_EN adds a 32-step shift-add UMUL/SMUL; without it those opcodes retire as NOPs.
module ex_stage #(
    parameter int PC_SIZE   = 32,
    parameter int INST_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [PC_SIZE-1:0]   pcplus4,
    input  logic [INST_SIZE-1:0] valA,
    input  logic [INST_SIZE-1:0] valB,
    input  logic                 a,
    input  logic [5:0]           op3,
    input  logic                 i,
    input  logic [12:0]          imm13,
    input  logic [21:0]          disp22,
    input  logic [1:0]           op,
    input  logic [3:0]           cond,
    input  logic [2:0]           op2,
    input  logic [4:0]           rd,
    input  logic [29:0]          disp30,
    output logic                 ex_valid,
    output logic [INST_SIZE-1:0] ex_result,
    output logic [INST_SIZE-1:0] ex_store_data,
    output logic [4:0]           ex_rd,
    output logic                 ex_wr_en,
    output logic                 ex_mem_rd,
    output logic                 ex_mem_wr,
    output logic                 branch_taken,
    output logic [PC_SIZE-1:0]   branch_target,
    output logic                 annul_next,
    output logic                 stall,
    output logic [3:0]           icc,
    output logic [INST_SIZE-1:0] y
);
    localparam int W = INST_SIZE;

    logic                 ex_valid_q, ex_wr_en_q, ex_mem_rd_q, ex_mem_wr_q, branch_taken_q, annul_next_q;
    logic [W-1:0]         ex_result_q, ex_store_data_q, y_q;
    logic [4:0]           ex_rd_q;
    logic [PC_SIZE-1:0]   branch_target_q;
    logic [3:0]           icc_q;

    logic [W-1:0]         op2val, res, y_new, mul_lo, mul_hi;
    logic [W:0]           sum_add, sum_sub;
    logic [PC_SIZE-1:0]   pc_cur, target;
    logic [3:0]           icc_new;
    logic [7:0]           cond_tab;
    logic [4:0]           rd_sel, mul_rd;
    logic                 v, c, cc, wy, known, taken, annul, mrd, mwr, issue, done;

    assign op2val   = i ? {{(W-13){imm13[12]}}, imm13} : valB;
    assign sum_add  = {1'b0, valA} + {1'b0, op2val};
    assign sum_sub  = {1'b0, valA} - {1'b0, op2val};
    assign pc_cur   = pcplus4 - PC_SIZE'(4);
    assign rd_sel   = op == 2'd1 ? 5'd15 : rd;
    // Bicc condition low bits index this table; cond[3] inverts the sense
    assign cond_tab = {icc_q[1], icc_q[3], icc_q[0], icc_q[0] | icc_q[2], icc_q[3] ^ icc_q[1],
                       icc_q[2] | (icc_q[3] ^ icc_q[1]), icc_q[2], 1'b0};
    assign icc_new  = {res[W-1], res == '0, v, c};
    assign y_new    = valA ^ op2val;

    always_comb begin
        res    = sum_add[W-1:0];
        v      = 1'b0;
        c      = 1'b0;
        cc     = 1'b0;
        wy     = 1'b0;
        known  = 1'b0;
        taken  = 1'b0;
        annul  = 1'b0;
        mrd    = 1'b0;
        mwr    = 1'b0;
        target = pc_cur + {{(PC_SIZE-24){disp22[21]}}, disp22, 2'b00};
        case (op)
            2'd0: begin
                taken = op2 == 3'd2 && (cond[3] ^ cond_tab[cond[2:0]]);
                annul = op2 == 3'd2 && a && (!taken || cond == 4'b1000);
                known = op2 == 3'd4;
                res   = W'({disp22, 10'b0});
            end
            2'd1: begin
                res    = W'(pc_cur);
                known  = 1'b1;
                taken  = 1'b1;
                target = pc_cur + PC_SIZE'({disp30, 2'b00});
            end
            2'd2: begin
                known = 1'b1;
                case (op3)
                    6'h00, 6'h10: begin
                        cc = op3[4];
                        v  = (valA[W-1] == op2val[W-1]) && (sum_add[W-1] != valA[W-1]);
                        c  = sum_add[W];
                    end
                    6'h04, 6'h14: begin
                        cc  = op3[4];
                        res = sum_sub[W-1:0];
                        v   = (valA[W-1] != op2val[W-1]) && (sum_sub[W-1] != valA[W-1]);
                        c   = sum_sub[W];
                    end
                    6'h01, 6'h11: begin cc = op3[4]; res = valA & op2val; end
                    6'h02, 6'h12: begin cc = op3[4]; res = valA | op2val; end
                    6'h03: res = valA ^ op2val;
                    6'h25: res = valA << op2val[4:0];
                    6'h26: res = valA >> op2val[4:0];
                    6'h27: res = W'($signed(valA) >>> op2val[4:0]);
                    6'h28: res = y_q;
                    6'h30: begin wy = 1'b1; known = 1'b0; end
                    6'h38: begin
                        res    = W'(pc_cur);
                        taken  = 1'b1;
                        target = PC_SIZE'(sum_add[W-1:0]);
                    end
                    default: known = 1'b0;
                endcase
            end
            default: begin
                mrd   = ~op3[2];
                mwr   = op3[2];
                known = ~op3[2];
            end
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state_q;
    logic [4:0]        cnt_q, mrd_q;
    logic [W-1:0]      ma_q;
    logic [2*W-1:0]    prod_q, prod_fin;
    logic [W:0]        acc;
    logic              neg_q, is_mul;

    assign is_mul   = op == 2'd2 && op3[5:1] == 5'b00101;
    assign acc      = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, ma_q} : '0);
    assign prod_fin = neg_q ? -prod_q : prod_q;
    assign {mul_hi, mul_lo} = prod_fin;
    assign mul_rd   = mrd_q;
    // DONE also stalls so the held follower is taken only once the FSM is back in IDLE
    assign stall    = state_q != IDLE;
    assign issue    = in_valid && state_q == IDLE && !is_mul;
    assign done     = state_q == DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid && is_mul) begin
                    state_q <= BUSY;
                    cnt_q   <= 5'd0;
                    mrd_q   <= rd;
                    neg_q   <= op3[0] && (valA[W-1] ^ op2val[W-1]);
                    ma_q    <= (op3[0] && valA[W-1]) ? -valA : valA;
                    prod_q  <= {{W{1'b0}}, (op3[0] && op2val[W-1]) ? -op2val : op2val};
                end
                BUSY: begin
                    prod_q <= {acc, prod_q[W-1:1]};
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign stall  = 1'b0;
    assign issue  = in_valid;
    assign done   = 1'b0;
    assign mul_lo = '0;
    assign mul_hi = '0;
    assign mul_rd = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q      <= 1'b0;
            ex_result_q     <= '0;
            ex_store_data_q <= '0;
            ex_rd_q         <= '0;
            ex_wr_en_q      <= 1'b0;
            ex_mem_rd_q     <= 1'b0;
            ex_mem_wr_q     <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            annul_next_q    <= 1'b0;
            icc_q           <= '0;
            y_q             <= '0;
        end else begin
            ex_valid_q      <= issue | done;
            ex_result_q     <= done ? mul_lo : res;
            ex_store_data_q <= valB;
            ex_rd_q         <= done ? mul_rd : rd_sel;
            ex_wr_en_q      <= done ? mul_rd != 5'd0 : issue && known && rd_sel != 5'd0;
            ex_mem_rd_q     <= issue & mrd;
            ex_mem_wr_q     <= issue & mwr;
            branch_taken_q  <= issue & taken;
            branch_target_q <= target;
            annul_next_q    <= issue & annul;
            if (issue && cc) icc_q <= icc_new;
            if (issue && wy) y_q <= y_new;
            else if (done) y_q <= mul_hi;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_result     = ex_result_q;
    assign ex_store_data = ex_store_data_q;
    assign ex_rd         = ex_rd_q;
    assign ex_wr_en      = ex_wr_en_q;
    assign ex_mem_rd     = ex_mem_rd_q;
    assign ex_mem_wr     = ex_mem_wr_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign annul_next    = annul_next_q;
    assign icc           = icc_q;
    assign y             = y_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized scoreboard bench for ex_stage against an instruction-level reference model.
module tb_ex_stage;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
    logic [31:0] pcplus4 = '0, valA = '0, valB = '0;
    logic        a = 1'b0, i = 1'b0;
    logic [5:0]  op3 = '0;
    logic [12:0] imm13 = '0;
    logic [21:0] disp22 = '0;
    logic [1:0]  op = '0;
    logic [3:0]  cond = '0;
    logic [2:0]  op2 = '0;
    logic [4:0]  rd = '0;
    logic [29:0] disp30 = '0;
    logic        ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr, branch_taken, annul_next, stall;
    logic [31:0] ex_result, ex_store_data, branch_target, y;
    logic [4:0]  ex_rd;
    logic [3:0]  icc;

    ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pcplus4(pcplus4), .valA(valA), .valB(valB),
        .a(a), .op3(op3), .i(i), .imm13(imm13), .disp22(disp22), .op(op), .cond(cond), .op2(op2),
        .rd(rd), .disp30(disp30), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .branch_taken(branch_taken), .branch_target(branch_target),
        .annul_next(annul_next), .stall(stall), .icc(icc), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [5:0]  op3;
        logic [2:0]  op2;
        logic [3:0]  cond;
        logic        a, i;
        logic [12:0] imm13;
        logic [21:0] disp22;
        logic [29:0] disp30;
        logic [4:0]  rd;
        logic [31:0] va, vb, pc;
    } ins_t;

    typedef struct packed {
        logic [31:0] res, store, tgt, y;
        logic [4:0]  rd;
        logic [3:0]  icc;
        logic        wr, mrd, mwr, tk, an, c_res, c_store, c_tgt;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  icc_m = '0;
    logic [31:0] y_m = '0;
    int          n_vec = 0, n_err = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic logic bicc(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, v, c;
        {n, z, v, c} = f;
        case (cd)
            4'd0:  return 1'b0;           // BN
            4'd1:  return z;              // BE
            4'd2:  return z | (n ^ v);    // BLE
            4'd3:  return n ^ v;          // BL
            4'd4:  return c | z;          // BLEU
            4'd5:  return c;              // BCS
            4'd6:  return n;              // BNEG
            4'd7:  return v;              // BVS
            4'd8:  return 1'b1;           // BA
            4'd9:  return !z;             // BNE
            4'd10: return !(z | (n ^ v)); // BG
            4'd11: return !(n ^ v);       // BGE
            4'd12: return !(c | z);       // BGU
            4'd13: return !c;             // BCC
            4'd14: return !n;             // BPOS
            default: return !v;           // BVC
        endcase
    endfunction

    task automatic model(input ins_t t, output exp_t e);
        logic [31:0]        o2, r;
        logic signed [31:0] d22;
        logic [4:0]         sh;
        longint             s;
        logic [63:0]        p;
        logic               wr, v, c;
        e  = '0;
        r  = '0;
        wr = 1'b0;
        v  = 1'b0;
        c  = 1'b0;
        o2 = t.i ? {{19{t.imm13[12]}}, t.imm13} : t.vb;
        sh = o2[4:0];
        e.rd = t.op == 2'd1 ? 5'd15 : t.rd;
        case (t.op)
            2'd2: begin
                e.c_res = 1'b1;
                wr = 1'b1;
                case (t.op3)
                    6'h00, 6'h10: begin
                        r = t.va + o2;
                        s = longint'($signed(t.va)) + longint'($signed(o2));
                        v = s != longint'($signed(r));
                        c = (64'(t.va) + 64'(o2)) > 64'hFFFF_FFFF;
                    end
                    6'h04, 6'h14: begin
                        r = t.va - o2;
                        s = longint'($signed(t.va)) - longint'($signed(o2));
                        v = s != longint'($signed(r));
                        c = t.va < o2;
                    end
                    6'h01, 6'h11: r = t.va & o2;
                    6'h02, 6'h12: r = t.va | o2;
                    6'h03: r = t.va ^ o2;
                    6'h25: r = t.va << sh;
                    6'h26: r = t.va >> sh;
                    6'h27: r = (t.va >> sh) | (t.va[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                    6'h28: r = y_m;
                    6'h30: begin y_m = t.va ^ o2; wr = 1'b0; e.c_res = 1'b0; end
                    6'h38: begin r = t.pc - 32'd4; e.tk = 1'b1; e.tgt = t.va + o2; e.c_tgt = 1'b1; end
`ifdef EX_MUL_EN
                    6'h0A, 6'h0B: begin
                        p = t.op3[0] ? 64'(longint'($signed(t.va)) * longint'($signed(o2)))
                                     : 64'(t.va) * 64'(o2);
                        r = p[31:0];
                        y_m = p[63:32];
                    end
`endif
                    default: begin wr = 1'b0; e.c_res = 1'b0; end
                endcase
                if (t.op3 inside {6'h10, 6'h11, 6'h12, 6'h14}) icc_m = {r[31], r == 32'd0, v, c};
            end
            2'd3: begin
                r = t.va + o2;
                e.c_res = 1'b1;
                e.store = t.vb;
                e.c_store = 1'b1;
                e.mrd = !t.op3[2];
                e.mwr = t.op3[2];
                wr = e.mrd;
            end
            2'd1: begin
                r = t.pc - 32'd4;
                e.c_res = 1'b1;
                wr = 1'b1;
                e.tk = 1'b1;
                e.tgt = t.pc - 32'd4 + {t.disp30, 2'b00};
                e.c_tgt = 1'b1;
            end
            default: begin
                if (t.op2 == 3'd2) begin
                    d22 = $signed(t.disp22);
                    e.tk = bicc(t.cond, icc_m);
                    e.an = t.a && (!e.tk || t.cond == 4'b1000);
                    e.tgt = t.pc - 32'd4 + 32'(d22 * 4);
                    e.c_tgt = 1'b1;
                end else if (t.op2 == 3'd4) begin
                    r = {t.disp22, 10'b0};
                    e.c_res = 1'b1;
                    wr = 1'b1;
                end
            end
        endcase
        e.wr  = wr && e.rd != 5'd0;
        e.res = r;
        e.icc = icc_m;
        e.y   = y_m;
    endtask

    task automatic apply(input ins_t t);
        {op, op3, op2, cond, a, i, imm13, disp22, disp30, rd, valA, valB, pcplus4} = t;
        in_valid = 1'b1;
    endtask

    task automatic drive(input ins_t t);
        exp_t e;
        apply(t);
        model(t, e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic ins_t rand_ins();
        logic [5:0] alu[15] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h10, 6'h11, 6'h12, 6'h14,
                                6'h25, 6'h26, 6'h27, 6'h28, 6'h30, 6'h38};
        ins_t t;
        t = '0;
        t.op     = 2'($urandom_range(0, 3));
        t.op2    = $urandom_range(0, 1) ? 3'd2 : 3'd4;
        t.op3    = t.op == 2'd2 ? alu[$urandom_range(0, 14)] : ($urandom_range(0, 1) ? 6'h04 : 6'h00);
        t.cond   = 4'($urandom);
        t.a      = 1'($urandom);
        t.i      = 1'($urandom);
        t.imm13  = 13'($urandom);
        t.disp22 = 22'($urandom);
        t.disp30 = 30'($urandom);
        t.rd     = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
        t.va     = rval();
        t.vb     = rval();
        t.pc     = $urandom & 32'hFFFF_FFFC;
        return t;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ex_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got ex_valid=1 want no pending instruction");
                end else begin
                    e = q.pop_front();
                    chk("rd", ex_rd, e.rd);
                    chk("wr_en", ex_wr_en, e.wr);
                    chk("mem_rd", ex_mem_rd, e.mrd);
                    chk("mem_wr", ex_mem_wr, e.mwr);
                    chk("taken", branch_taken, e.tk);
                    chk("annul", annul_next, e.an);
                    chk("icc", icc, e.icc);
                    chk("y", y, e.y);
                    if (e.c_res) chk("result", ex_result, e.res);
                    if (e.c_store) chk("store_data", ex_store_data, e.store);
                    if (e.c_tgt) chk("target", branch_target, e.tgt);
                end
            end else begin
                chk("bubble_ctl", {ex_wr_en, ex_mem_rd, ex_mem_wr, branch_taken, annul_next}, 0);
            end
`ifndef EX_MUL_EN
            chk("stall", stall, 0);
`endif
        end
    end

    initial begin
        ins_t t;
        int   n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_result", ex_result, 0);
        chk("rst_ctl", {ex_wr_en, ex_mem_rd, ex_mem_wr, branch_taken, annul_next, stall}, 0);
        chk("rst_target", branch_target, 0);
        chk("rst_icc", icc, 0);
        chk("rst_y", y, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        t = '0; t.op = 2'd2; t.op3 = 6'h10; t.va = 32'h7FFF_FFFF; t.i = 1'b1; t.imm13 = 13'd1; t.rd = 5'd1;
        drive(t);
        chk("addcc_ovf_result", ex_result, 32'h8000_0000);
        chk("addcc_ovf_icc", icc, 4'b1010);

        t = '0; t.op = 2'd2; t.op3 = 6'h14; t.va = 32'd5; t.vb = 32'd5; t.rd = 5'd2;
        drive(t);
        t = '0; t.op2 = 3'd2; t.cond = 4'd1; t.pc = 32'h200; t.disp22 = 22'h3FFFFF;
        drive(t);
        chk("be_taken", branch_taken, 1);
        chk("be_annul", annul_next, 0);
        chk("be_target", branch_target, 32'h1F8);

        t = '0; t.op2 = 3'd2; t.cond = 4'd9; t.a = 1'b1; t.pc = 32'h300;
        drive(t);
        chk("bne_taken", branch_taken, 0);
        chk("bne_annul", annul_next, 1);

        t = '0; t.op = 2'd1; t.pc = 32'h104; t.disp30 = 30'd4;
        drive(t);
        chk("call_rd", ex_rd, 15);
        chk("call_result", ex_result, 32'h100);
        chk("call_target", branch_target, 32'h110);

        t = '0; t.op = 2'd2; t.op3 = 6'h0B; t.va = 32'hFFFF_FFFD; t.vb = 32'd7; t.rd = 5'd3;
        drive(t);
`ifdef EX_MUL_EN
        in_valid = 1'b0;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("smul_stall_cycles", n, 33);
        chk("smul_valid", ex_valid, 1);
        chk("smul_lo", ex_result, 32'hFFFF_FFEB);
        chk("smul_hi", y, 32'hFFFF_FFFF);
        t.op3 = 6'h0A;
        apply(t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("umul_busy_stall", stall, 1);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_after_reset", stall, 0);
        reset = 1'b0;
        icc_m = '0;
        y_m   = '0;
        q.delete();
        mon_en = 1'b1;
`else
        chk("mul_nop_valid", ex_valid, 1);
        chk("mul_nop_wr_en", ex_wr_en, 0);
`endif

        repeat (500) begin
            if ($urandom_range(0, 3) == 0) bubble();
            else drive(rand_ins());
        end
        bubble();
        bubble();
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
